alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Sequencing controller that places the 8-bit ALU behind the UART. It collects three bytes from the UART receiver (operand A, operand B, opcode), drives the ALU operands and opcode from registers, and hands the combinational ALU result to the UART transmitter as a single byte. It also resynchronises the byte stream if a frame is left incomplete.

## Interface
- `DBIT`, 8: data width. Equals the ALU operand/result width and the UART byte width.
- `OPCODE`, 6: ALU opcode width.
- `TIMEOUT`, 1_000_000: idle clock cycles allowed between bytes of one frame. 0 disables the timeout.

- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `rx_data`  in  DBIT: received byte, valid while `rx_done_tick` is high.
- `rx_done_tick`  in  1: one-cycle pulse from the UART receiver per byte.
- `tx_done_tick`  in  1: one-cycle pulse from the UART transmitter when a byte finishes.
- `alu_result`  in  DBIT: combinational result from the ALU.
- `alu_a`  out  DBIT: registered operand A to the ALU.
- `alu_b`  out  DBIT: registered operand B to the ALU.
- `alu_op`  out  OPCODE: registered opcode to the ALU.
- `tx_data`  out  DBIT: registered byte to the transmitter.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `busy`  out  1: high while a result is being sent.

## Operation
- FSM states: `WAIT_A`, `WAIT_B`, `WAIT_OP`, `SEND`, `WAIT_TX`. Reset state is `WAIT_A`.
- `WAIT_A`: on `rx_done_tick`, `alu_a <= rx_data`, go to `WAIT_B`.
- `WAIT_B`: on `rx_done_tick`, `alu_b <= rx_data`, go to `WAIT_OP`.
- `WAIT_OP`: on `rx_done_tick`, `alu_op <= rx_data[OPCODE-1:0]`, go to `SEND`. Upper byte bits are discarded without error.
- `SEND`: lasts one cycle. `tx_data <= alu_result` and `tx_start <= 1`, then go to `WAIT_TX`.
- `WAIT_TX`: wait for `tx_done_tick`, then go to `WAIT_A`. There is no timeout in this state.
- `busy` = (state == `SEND`) or (state == `WAIT_TX`). Decoded from the state register.
- `rx_done_tick` in `SEND` or `WAIT_TX` is dropped. Registers are unchanged and no byte is buffered.
- `tx_done_tick` outside `WAIT_TX` is ignored.
- Undefined opcodes are passed through unchanged. The ALU returns 0 for them and that 0 is transmitted.
- Inter-byte timeout:
  - Counter is cleared on entry to `WAIT_A` and on every accepted byte.
  - It increments each cycle in `WAIT_B` and `WAIT_OP`.
  - When it reaches `TIMEOUT` without a byte, state goes to `WAIT_A`. `alu_a` and `alu_b` hold their values and no transmission occurs.
  - Counter width is `$clog2(TIMEOUT+1)`. It saturates, never wraps.
  - If `rx_done_tick` arrives in the same cycle the timeout fires, the byte wins: it is accepted and the FSM advances.
- Reset, at any point including mid-frame or mid-`WAIT_TX`:
  - State goes to `WAIT_A`.
  - `alu_a`, `alu_b`, `alu_op`, `tx_data` = 0.
  - `tx_start`, `busy` = 0.
  - Timeout counter = 0.
  - Any transmission in progress is abandoned.

## Timing
- All outputs are registered except `busy`, which decodes the state register.
- Each operand register updates the cycle after its `rx_done_tick` (edge n gives the new value from n+1).
- Opcode byte sampled at edge n:
  - n+1: `alu_op` valid, state = `SEND`. The ALU settles within that cycle.
  - n+2: `tx_data` = result, `tx_start` = 1 for exactly one cycle, state = `WAIT_TX`.
- `tx_data` is held stable until the next `SEND`.
- `tx_done_tick` sampled at edge m gives state `WAIT_A` and `busy` = 0 from m+1. A byte arriving at m+1 is accepted.
- No back-to-back `tx_start`. At most one `tx_start` per three received bytes.

## Test plan
- Reset, then bytes 0x05, 0x03, 0x20 (ADD) -> `alu_a`=0x05, `alu_b`=0x03, `alu_op`=0x20; exactly one `tx_start` with `tx_data`=0x08 two cycles after the third `rx_done_tick`.
- Bytes 0x03, 0x05, 0x22 (SUB) -> `tx_data`=0xFE. Bytes 0xF0, 0x04, 0x03 (SRA) -> `tx_data`=0xFF. Bytes 0xF0, 0x04, 0x02 (SRL) -> `tx_data`=0x0F.
- Opcode byte 0xE5 after 0x0C, 0x0A -> `alu_op`=0x25 (OR), `tx_data`=0x0E; byte 0x3F (undefined) -> `tx_data`=0x00.
- `TIMEOUT`=16: send 0x11, wait 16 cycles, then 0x22, 0x33, 0x20 -> frame restarts at 0x22; `alu_a`=0x22, `alu_b`=0x33, `tx_data`=0x55. Repeat with the byte landing on the timeout cycle -> byte accepted as B.
- During `WAIT_TX`, pulse `rx_done_tick` with 0x77 -> dropped, `alu_a` unchanged, `busy`=1 until `tx_done_tick`; the next frame computes normally.
- Assert `reset` for one cycle in `WAIT_OP` and again in `WAIT_TX` -> all outputs 0, state `WAIT_A`, no `tx_start`; the following 0x01, 0x01, 0x20 yields `tx_data`=0x02.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: gathers A, B and opcode bytes from the UART and sends back one ALU result byte
module alu_uart_ctrl #(
  parameter int DBIT    = 8,
  parameter int OPCODE  = 6,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBIT-1:0]   rx_data,
  input  logic              rx_done_tick,
  input  logic              tx_done_tick,
  input  logic [DBIT-1:0]   alu_result,
  output logic [DBIT-1:0]   alu_a,
  output logic [DBIT-1:0]   alu_b,
  output logic [OPCODE-1:0] alu_op,
  output logic [DBIT-1:0]   tx_data,
  output logic              tx_start,
  output logic              busy
);
  localparam logic [2:0] WAIT_A  = 3'd0;
  localparam logic [2:0] WAIT_B  = 3'd1;
  localparam logic [2:0] WAIT_OP = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] WAIT_TX = 3'd4;
  // a zero TIMEOUT still needs a one-bit counter so the declaration stays legal
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [2:0]    state, state_next;
  logic [CW-1:0] cnt;
  logic          collecting, expired;

  assign collecting = (state == WAIT_B) || (state == WAIT_OP);
  assign expired    = (TIMEOUT > 0) && (cnt == LIMIT);
  assign busy       = (state == SEND) || (state == WAIT_TX);

  // next-state: an incoming byte takes priority over a timeout firing in the same cycle
  always_comb begin
    state_next = state;
    case (state)
      WAIT_A:  state_next = rx_done_tick ? WAIT_B : WAIT_A;
      WAIT_B:  state_next = rx_done_tick ? WAIT_OP : (expired ? WAIT_A : WAIT_B);
      WAIT_OP: state_next = rx_done_tick ? SEND : (expired ? WAIT_A : WAIT_OP);
      SEND:    state_next = WAIT_TX;
      WAIT_TX: state_next = tx_done_tick ? WAIT_A : WAIT_TX;
      default: state_next = WAIT_A;
    endcase
  end

  // state, operand/opcode capture and the result hand-off to the transmitter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= (state == SEND);
      if (state == WAIT_A && rx_done_tick) alu_a <= rx_data;
      if (state == WAIT_B && rx_done_tick) alu_b <= rx_data;
      if (state == WAIT_OP && rx_done_tick) alu_op <= rx_data[OPCODE-1:0];
      if (state == SEND) tx_data <= alu_result;
    end
  end

  // inter-byte idle counter: runs only mid-frame, cleared by any accepted byte, saturates at the limit
  always_ff @(posedge clk) begin
    if (reset || !collecting || rx_done_tick || TIMEOUT == 0)
      cnt <= '0;
    else if (cnt != LIMIT)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed checks of the UART/ALU sequencing controller
module tb_alu_uart_ctrl;
  logic       clk = 0;
  logic       reset = 1;
  logic [7:0] rx_data = 0;
  logic       rx_done_tick = 0;
  logic       tx_done_tick = 0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy;
  int total = 0;
  int bad = 0;

  alu_uart_ctrl #(.DBIT(8), .OPCODE(6), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_done_tick(tx_done_tick), .alu_result(alu_result), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .tx_data(tx_data), .tx_start(tx_start), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      6'h20: alu_result = alu_a + alu_b;
      6'h22: alu_result = alu_a - alu_b;
      6'h02: alu_result = alu_a >> alu_b;
      6'h03: alu_result = 8'($signed(alu_a) >>> alu_b);
      6'h25: alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1;
    @(negedge clk);
    rx_done_tick = 0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] res);
    send_byte(a);
    chk("alu_a", alu_a, a);
    send_byte(b);
    chk("alu_b", alu_b, b);
    send_byte(op);
    chk("alu_op", alu_op, op[5:0]);
    chk("busy_send", busy, 1);
    chk("tx_start_early", tx_start, 0);
    @(negedge clk);
    chk("tx_start", tx_start, 1);
    chk("tx_data", tx_data, res);
    @(negedge clk);
    chk("tx_start_one", tx_start, 0);
    chk("busy_wait_tx", busy, 1);
  endtask

  task automatic finish_tx();
    @(negedge clk);
    tx_done_tick = 1;
    @(negedge clk);
    tx_done_tick = 0;
    chk("busy_idle", busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, alu_a, 0);
    chk({tag, "_b"}, alu_b, 0);
    chk({tag, "_op"}, alu_op, 0);
    chk({tag, "_tx"}, tx_data, 0);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    chk_zero("reset");
    frame(8'h05, 8'h03, 8'h20, 8'h08);
    finish_tx();
    frame(8'h03, 8'h05, 8'h22, 8'hFE);
    finish_tx();
    frame(8'hF0, 8'h04, 8'h03, 8'hFF);
    finish_tx();
    frame(8'hF0, 8'h04, 8'h02, 8'h0F);
    finish_tx();
    frame(8'h0C, 8'h0A, 8'hE5, 8'h0E);
    finish_tx();
    frame(8'h0C, 8'h0A, 8'h3F, 8'h00);
    finish_tx();
    chk("tx_hold", tx_data, 8'h00);
    // abandoned frame: long silence after A restarts the frame
    send_byte(8'h11);
    repeat (20) @(negedge clk);
    chk("timeout_busy", busy, 0);
    chk("timeout_hold_a", alu_a, 8'h11);
    frame(8'h22, 8'h33, 8'h20, 8'h55);
    finish_tx();
    // byte landing exactly on the timeout cycle is accepted as B
    send_byte(8'h44);
    repeat (15) @(negedge clk);
    send_byte(8'h55);
    chk("collide_a", alu_a, 8'h44);
    chk("collide_b", alu_b, 8'h55);
    send_byte(8'h20);
    chk("collide_busy", busy, 1);
    @(negedge clk);
    chk("collide_start", tx_start, 1);
    chk("collide_tx", tx_data, 8'h99);
    finish_tx();
    // byte during WAIT_TX is dropped
    frame(8'h10, 8'h20, 8'h25, 8'h30);
    send_byte(8'h77);
    chk("drop_a", alu_a, 8'h10);
    chk("drop_b", alu_b, 8'h20);
    chk("drop_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("drop_busy_hold", busy, 1);
    finish_tx();
    frame(8'h07, 8'h02, 8'h22, 8'h05);
    finish_tx();
    // reset in WAIT_OP
    send_byte(8'h09);
    send_byte(8'h08);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk_zero("rst_op");
    // reset in WAIT_TX
    frame(8'h06, 8'h06, 8'h20, 8'h0C);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk_zero("rst_tx");
    @(negedge clk);
    chk("rst_tx_nostart", tx_start, 0);
    frame(8'h01, 8'h01, 8'h20, 8'h02);
    finish_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
